// File: rtl/spi_byte_sequencer_if.sv
// Signal bundle for spi_byte_sequencer: user push/pop side plus controller handshake.
// SPI_SEQ_STATS_EN adds the o_TX_Total / o_RX_Total statistics outputs.
interface spi_byte_sequencer_if #(
    parameter int DEPTH            = 8,
    parameter int MAX_BYTES_PER_CS = 1
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);

    logic          i_Push_DV;
    logic [7:0]    i_Push_Byte;
    logic          o_Push_Ready;
    logic [7:0]    o_TX_Byte;
    logic          o_TX_DV;
    logic [CW-1:0] o_TX_Count;
    logic          i_TX_Ready;
    logic          i_RX_DV;
    logic [7:0]    i_RX_Byte;
    logic          i_Pop_Req;
    logic          o_Pop_DV;
    logic [7:0]    o_Pop_Byte;
    logic          o_RX_Empty;
    logic [LW-1:0] o_TX_Level;
    logic [LW-1:0] o_RX_Level;
    logic          o_RX_Ovf;
`ifdef SPI_SEQ_STATS_EN
    logic [15:0]   o_TX_Total;
    logic [15:0]   o_RX_Total;
`endif

    // master: the sequencer itself; slave: user logic and SPI controller around it
    modport master (
`ifdef SPI_SEQ_STATS_EN
        output o_TX_Total, output o_RX_Total,
`endif
        input  i_Push_DV, i_Push_Byte, i_TX_Ready, i_RX_DV, i_RX_Byte, i_Pop_Req,
        output o_Push_Ready, o_TX_Byte, o_TX_DV, o_TX_Count, o_Pop_DV, o_Pop_Byte,
        output o_RX_Empty, o_TX_Level, o_RX_Level, o_RX_Ovf
    );

    modport slave (
`ifdef SPI_SEQ_STATS_EN
        input  o_TX_Total, input o_RX_Total,
`endif
        output i_Push_DV, i_Push_Byte, i_TX_Ready, i_RX_DV, i_RX_Byte, i_Pop_Req,
        input  o_Push_Ready, o_TX_Byte, o_TX_DV, o_TX_Count, o_Pop_DV, o_Pop_Byte,
        input  o_RX_Empty, o_TX_Level, o_RX_Level, o_RX_Ovf
    );
endinterface

// File: rtl/spi_byte_sequencer.sv
// TX/RX byte FIFOs feeding SPI_Controller_With_Single_CS one byte per chip-select.
// Optional macro SPI_SEQ_STATS_EN adds 16-bit wrapping TX/RX transfer counters.
module spi_byte_sequencer #(
    parameter int DEPTH            = 8,
    parameter int MAX_BYTES_PER_CS = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    spi_byte_sequencer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SEND     = 2'd1;
    localparam logic [1:0] WAIT_RX  = 2'd2;
    localparam logic [1:0] WAIT_RDY = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [LW-1:0] tx_lvl_q, rx_lvl_q;
    logic          tx_dv_q, pop_dv_q, ovf_q;
    logic [7:0]    tx_byte_q, pop_byte_q;
    logic          tx_push, tx_pop, rx_wr, rx_pop;

    function automatic logic [LW-1:0] next_level(input logic [LW-1:0] lvl,
                                                 input logic inc, input logic dec);
        logic [LW-1:0] r;
        r = lvl;
        if (inc && !dec)      r = lvl + LW'(1);
        else if (dec && !inc) r = lvl - LW'(1);
        return r;
    endfunction

    // The head is popped on the IDLE->SEND edge so o_TX_Byte/o_TX_DV are registered in SEND
    assign tx_push = bus.i_Push_DV && (tx_lvl_q != FULL);
    assign tx_pop  = (state_q == IDLE) && (tx_lvl_q != '0) && bus.i_TX_Ready;
    assign rx_pop  = bus.i_Pop_Req && (rx_lvl_q != '0);
    assign rx_wr   = bus.i_RX_DV && ((rx_lvl_q != FULL) || rx_pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (tx_pop) state_d = SEND;
            SEND:     state_d = WAIT_RX;
            WAIT_RX:  if (bus.i_RX_DV) state_d = WAIT_RDY;
            WAIT_RDY: if (bus.i_TX_Ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= IDLE;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_lvl_q   <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_lvl_q   <= '0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= '0;
            pop_dv_q   <= 1'b0;
            pop_byte_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
            tx_lvl_q <= next_level(tx_lvl_q, tx_push, tx_pop);
            tx_dv_q  <= tx_pop;
            if (tx_pop) tx_byte_q <= tx_mem_q[tx_rd_q];

            if (rx_wr)  rx_wr_q <= rx_wr_q + AW'(1);
            if (rx_pop) rx_rd_q <= rx_rd_q + AW'(1);
            rx_lvl_q <= next_level(rx_lvl_q, rx_wr, rx_pop);
            pop_dv_q <= rx_pop;
            if (rx_pop) pop_byte_q <= rx_mem_q[rx_rd_q];
            if (bus.i_RX_DV && !rx_wr) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= bus.i_Push_Byte;
        if (rx_wr)   rx_mem_q[rx_wr_q] <= bus.i_RX_Byte;
    end

    assign bus.o_Push_Ready = (tx_lvl_q != FULL);
    assign bus.o_TX_Byte    = tx_byte_q;
    assign bus.o_TX_DV      = tx_dv_q;
    assign bus.o_TX_Count   = CW'(1);
    assign bus.o_Pop_DV     = pop_dv_q;
    assign bus.o_Pop_Byte   = pop_byte_q;
    assign bus.o_RX_Empty   = (rx_lvl_q == '0);
    assign bus.o_TX_Level   = tx_lvl_q;
    assign bus.o_RX_Level   = rx_lvl_q;
    assign bus.o_RX_Ovf     = ovf_q;

`ifdef SPI_SEQ_STATS_EN
    logic [15:0] tx_total_q, rx_total_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tx_total_q <= '0;
            rx_total_q <= '0;
        end else begin
            if (state_q == SEND) tx_total_q <= tx_total_q + 16'd1;
            if (rx_wr)           rx_total_q <= rx_total_q + 16'd1;
        end
    end

    assign bus.o_TX_Total = tx_total_q;
    assign bus.o_RX_Total = rx_total_q;
`endif
endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Self-checking bench for spi_byte_sequencer with a behavioural SPI controller stand-in.
`timescale 1ns/1ps
module tb_spi_byte_sequencer;
    localparam int DEPTH = 8;
    localparam int MAXB  = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_byte_sequencer_if #(.DEPTH(DEPTH), .MAX_BYTES_PER_CS(MAXB)) bus ();
    spi_byte_sequencer #(.DEPTH(DEPTH), .MAX_BYTES_PER_CS(MAXB)) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic        pop_main    = 1'b0;
    logic        pop_p       = 1'b0;
    logic        ready_en    = 1'b1;
    logic        reply_fixed = 1'b1;
    logic [7:0]  reply_val   = 8'h00;
    int unsigned xfer_len    = 3;
    logic        pop_with_rx = 1'b0;
    logic        busy        = 1'b0;
    logic        mon_en      = 1'b0;
    int unsigned dv_count    = 0;
    logic [7:0]  last_pop    = 8'h00;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_m[$];
    logic [7:0] pop_exp[$];
    logic       ovf_m = 1'b0;

    assign bus.i_Pop_Req = pop_main | pop_p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: updated at each rising edge from the stimulus only
    initial begin : model
        forever begin
            @(posedge clk);
            if (rst) begin
                tx_exp.delete();
                rx_m.delete();
                ovf_m = 1'b0;
            end else begin
                if (bus.i_Push_DV && tx_exp.size() < DEPTH) tx_exp.push_back(bus.i_Push_Byte);
                if (bus.i_Pop_Req && rx_m.size() > 0) pop_exp.push_back(rx_m.pop_front());
                if (bus.i_RX_DV) begin
                    if (rx_m.size() < DEPTH) rx_m.push_back(bus.i_RX_Byte);
                    else ovf_m = 1'b1;
                end
            end
        end
    end

    // Controller stand-in: checks each issued byte, replies after xfer_len cycles
    initial begin : periph
        logic [7:0]  pend;
        int unsigned cnt;
        pend = 8'h00;
        cnt  = 0;
        bus.i_RX_DV    = 1'b0;
        bus.i_RX_Byte  = 8'h00;
        bus.i_TX_Ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_RX_DV = 1'b0;
            pop_p       = 1'b0;
            if (bus.o_TX_DV === 1'b1) begin
                dv_count++;
                check("tx_dv_while_busy", 32'(busy), 0);
                check("tx_dv_ready", 32'(bus.i_TX_Ready), 1);
                check("tx_dv_expected", 32'(tx_exp.size() != 0), 1);
                if (tx_exp.size() != 0) check("tx_byte", bus.o_TX_Byte, tx_exp.pop_front());
                pend = reply_fixed ? reply_val : bus.o_TX_Byte;
                busy = 1'b1;
                cnt  = xfer_len;
            end else if (busy) begin
                if (cnt == 0) begin
                    bus.i_RX_DV   = 1'b1;
                    bus.i_RX_Byte = pend;
                    pop_p         = pop_with_rx;
                    busy          = 1'b0;
                end else begin
                    cnt--;
                end
            end
            bus.i_TX_Ready = ready_en && !busy;
        end
    end

    initial begin : pop_mon
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (pop_exp.size() > 0) begin
                    e = pop_exp.pop_front();
                    check("pop_dv", 32'(bus.o_Pop_DV), 1);
                    check("pop_byte", bus.o_Pop_Byte, e);
                    last_pop = bus.o_Pop_Byte;
                end else if (bus.o_Pop_DV !== 1'b0) begin
                    check("pop_dv_spurious", 32'(bus.o_Pop_DV), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_Push_DV = 1'b0;
        pop_main = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic push(input logic [7:0] b);
        bus.i_Push_DV   = 1'b1;
        bus.i_Push_Byte = b;
        @(negedge clk);
        bus.i_Push_DV   = 1'b0;
    endtask

    task automatic push_wait(input logic [7:0] b);
        int unsigned t;
        t = 0;
        while (bus.o_Push_Ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("push_ready_wait", 32'(bus.o_Push_Ready), 1);
        push(b);
    endtask

    task automatic wait_idle();
        int unsigned t;
        t = 0;
        while ((tx_exp.size() != 0 || busy) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("wait_idle_done", 32'(tx_exp.size() == 0 && !busy), 1);
        tick(3);
    endtask

    task automatic pop_n(input int unsigned n);
        pop_main = 1'b1;
        tick(n);
        pop_main = 1'b0;
        tick(2);
    endtask

    typedef struct {
        logic [7:0]  tx;
        logic [7:0]  rx;
        int unsigned xfer;
    } vec_t;

    initial begin : main
        vec_t        vecs[4];
        int unsigned d0;
        int unsigned t;

        vecs[0] = '{tx: 8'h01, rx: 8'hA5, xfer: 3};
        vecs[1] = '{tx: 8'hFF, rx: 8'h00, xfer: 0};
        vecs[2] = '{tx: 8'h00, rx: 8'hFF, xfer: 7};
        vecs[3] = '{tx: 8'h3C, rx: 8'hC3, xfer: 1};

        bus.i_Push_DV   = 1'b0;
        bus.i_Push_Byte = 8'h00;
        tick(3);
        rst = 1'b0;
        tick(1);
        mon_en = 1'b1;

        check("rst_tx_dv",      32'(bus.o_TX_DV), 0);
        check("rst_tx_byte",    bus.o_TX_Byte, 0);
        check("rst_pop_dv",     32'(bus.o_Pop_DV), 0);
        check("rst_pop_byte",   bus.o_Pop_Byte, 0);
        check("rst_rx_ovf",     32'(bus.o_RX_Ovf), 0);
        check("rst_push_ready", 32'(bus.o_Push_Ready), 1);
        check("rst_rx_empty",   32'(bus.o_RX_Empty), 1);
        check("rst_tx_level",   bus.o_TX_Level, 0);
        check("rst_rx_level",   bus.o_RX_Level, 0);
        check("tx_count",       bus.o_TX_Count, 1);

        // single-byte transactions from the vector table
        for (int i = 0; i < 4; i++) begin
            reply_fixed = 1'b1;
            reply_val   = vecs[i].rx;
            xfer_len    = vecs[i].xfer;
            d0 = dv_count;
            push(vecs[i].tx);
            wait_idle();
            check("vec_dv_count", dv_count - d0, 1);
            check("vec_rx_level", bus.o_RX_Level, 1);
            pop_n(1);
            check("vec_pop_byte", last_pop, vecs[i].rx);
            check("vec_rx_empty", 32'(bus.o_RX_Empty), 1);
        end

        // fill TX FIFO with the controller busy, then release it
        ready_en = 1'b0;
        reply_fixed = 1'b0;
        xfer_len = 2;
        tick(2);
        d0 = dv_count;
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        check("t2_push_ready_full", 32'(bus.o_Push_Ready), 0);
        check("t2_tx_level", bus.o_TX_Level, 8);
        push(8'hFF);
        check("t2_tx_level_ff", bus.o_TX_Level, 8);
        tick(10);
        check("t2_no_dv_not_ready", dv_count - d0, 0);
        ready_en = 1'b1;
        wait_idle();
        tick(20);
        check("t2_dv_count", dv_count - d0, 8);
        check("t2_rx_level", bus.o_RX_Level, 8);
        check("t2_rx_ovf", 32'(bus.o_RX_Ovf), 0);
        pop_n(8);
        check("t2_last_pop", last_pop, 8'h17);
        check("t2_rx_empty", 32'(bus.o_RX_Empty), 1);

        // loopback of 10 bytes with no pops overflows the RX FIFO
        for (int i = 0; i < 10; i++) push_wait(8'(8'h30 + i));
        wait_idle();
        check("t3_rx_level", bus.o_RX_Level, 8);
        check("t3_rx_ovf", 32'(bus.o_RX_Ovf), 32'(ovf_m));
        check("t3_rx_ovf_set", 32'(bus.o_RX_Ovf), 1);
        pop_n(8);
        check("t3_last_pop", last_pop, 8'h37);
        check("t3_ovf_sticky", 32'(bus.o_RX_Ovf), 1);

        // full RX FIFO with pop and write in the same cycle
        do_reset();
        check("t4_ovf_cleared", 32'(bus.o_RX_Ovf), 0);
        for (int i = 0; i < 8; i++) push_wait(8'(8'h40 + i));
        wait_idle();
        check("t4_rx_full", bus.o_RX_Level, 8);
        pop_with_rx = 1'b1;
        push(8'h99);
        wait_idle();
        pop_with_rx = 1'b0;
        check("t4_pop_during_write", last_pop, 8'h40);
        check("t4_rx_level", bus.o_RX_Level, 8);
        check("t4_rx_ovf", 32'(bus.o_RX_Ovf), 0);
        pop_n(8);
        check("t4_last_pop", last_pop, 8'h99);
        check("t4_rx_empty", 32'(bus.o_RX_Empty), 1);

        // reset while waiting for the RX byte with 3 bytes queued
        xfer_len = 20;
        d0 = dv_count;
        for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
        t = 0;
        while (dv_count == d0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t5_first_dv", dv_count - d0, 1);
        tick(3);
        check("t5_tx_level_pre", bus.o_TX_Level, 3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check("t5_tx_level", bus.o_TX_Level, 0);
        check("t5_rx_level", bus.o_RX_Level, 0);
        check("t5_tx_dv", 32'(bus.o_TX_DV), 0);
        d0 = dv_count;
        wait_idle();
        tick(20);
        check("t5_no_dv_after_rst", dv_count - d0, 0);
        check("t5_rx_captured", bus.o_RX_Level, 1);
        xfer_len = 2;
        push(8'h5A);
        wait_idle();
        check("t5_idle_resend", dv_count - d0, 1);
        pop_n(2);
        check("t5_last_pop", last_pop, 8'h5A);

`ifdef SPI_SEQ_STATS_EN
        do_reset();
        check("t6_tx_total_rst", bus.o_TX_Total, 0);
        check("t6_rx_total_rst", bus.o_RX_Total, 0);
        xfer_len = 1;
        for (int i = 0; i < 10; i++) begin
            push(8'(8'h60 + i));
            wait_idle();
            pop_n(1);
        end
        check("t6_tx_total", bus.o_TX_Total, 10);
        check("t6_rx_total", bus.o_RX_Total, 10);
        force dut.tx_total_q = 16'hFFFF;
        force dut.rx_total_q = 16'hFFFF;
        tick(1);
        release dut.tx_total_q;
        release dut.rx_total_q;
        push(8'h77);
        wait_idle();
        pop_n(1);
        check("t6_tx_wrap", bus.o_TX_Total, 0);
        check("t6_rx_wrap", bus.o_RX_Total, 0);
`endif

        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
